// File: rtl/mmu_pkg.sv
// mmu_pkg: shared MMU client indices and default RAM geometry
package mmu_pkg;
  localparam int NUM_CLIENTS = 2;
  localparam logic CLI_PTW = 1'b0;
  localparam logic CLI_ALLOC = 1'b1;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 64;
endpackage

// File: rtl/ram_2port.sv
// ram_2port: 1-write/1-read RAM with registered read and same-address write bypass
module ram_2port import mmu_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
    read_data <= (write_en && write_addr == read_addr) ? write_data : mem[read_addr];
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin, burst-limited sharing of one ram_2port between two MMU clients
module ram_port_arbiter import mmu_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLIENTS-1:0]            req,
  input  logic [NUM_CLIENTS-1:0]            we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata,
  output logic [NUM_CLIENTS-1:0]            gnt,
  output logic [NUM_CLIENTS-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic [15:0]                       busy_cnt
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_BURST - 1);
  logic ptr, last, has_last, sel, any, limit_hit, write_en;
  logic [CW-1:0] cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] a_g, read_addr, write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  // The unused port always points at ~addr so read_addr never equals write_addr
  always_comb begin
    limit_hit = has_last && last == ptr && cnt == LIMIT;
    sel = &req ? (limit_hit ? ~ptr : ptr) : req[CLI_ALLOC];
    any = rst_n && |req;
    gnt = any ? (sel ? 2'b10 : 2'b01) : 2'b00;
    cnt_n = (has_last && last == sel) ? (cnt == LIMIT ? cnt : cnt + 1'b1) : '0;
    a_g = sel ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
    write_en = any && we[sel];
    write_addr = any ? (write_en ? a_g : ~a_g) : '1;
    read_addr = any ? (write_en ? ~a_g : a_g) : '0;
    write_data = write_en ? (sel ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0]) : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= CLI_PTW;
      last <= CLI_PTW;
      has_last <= 1'b0;
      cnt <= '0;
      rvalid <= '0;
      busy_cnt <= '0;
    end else begin
      rvalid <= gnt & ~we;
      if (&req && busy_cnt != 16'hFFFF) busy_cnt <= busy_cnt + 1'b1;
      has_last <= any;
      cnt <= any ? cnt_n : '0;
      if (any) begin
        last <= sel;
        ptr <= cnt_n == LIMIT ? ~sel : sel;
      end
    end
  end
  ram_2port #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk(clk),
    .write_en(write_en),
    .write_addr(write_addr),
    .write_data(write_data),
    .read_addr(read_addr),
    .read_data(rdata)
  );
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed table, corner sequences and random traffic against a run-length model
module tb_ram_port_arbiter;
  localparam int MAX_BURST = 4;
  typedef struct {
    logic [1:0] req, we;
    logic [5:0] a0, a1;
    logic [63:0] d0, d1;
    logic [1:0] gnt, rv;
    logic [63:0] rd;
  } vec_t;
  logic clk = 1'b0, rst_n;
  logic [1:0] req, we, gnt, rvalid;
  logic [11:0] addr;
  logic [127:0] wdata;
  logic [63:0] rdata;
  logic [15:0] busy_cnt;
  int checks = 0, errors = 0;
  logic [63:0] m_mem [64];
  bit m_known [64];
  logic [1:0] m_rv;
  logic [63:0] m_rd;
  bit m_rd_known;
  logic [15:0] m_busy;
  logic m_pref, m_last;
  int m_run;
  int wait_cnt [2];
  vec_t tbl [9];

  ram_port_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(64), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rv = 2'b00;
    m_busy = '0;
    m_pref = 1'b0;
    m_last = 1'b0;
    m_run = 0;
    wait_cnt[0] = 0;
    wait_cnt[1] = 0;
  endtask

  // Model: the preferred client is the last one granted, unless it has used up
  // a full burst, in which case the other client is preferred
  task automatic cycle(input logic [1:0] r, w, input logic [5:0] a0, a1, input logic [63:0] d0, d1);
    logic g;
    logic [5:0] a;
    @(negedge clk);
    chk("rvalid", rvalid, m_rv);
    if (m_rv != 0 && m_rd_known) chk("rdata", rdata, m_rd);
    chk("busy_cnt", busy_cnt, m_busy);
    req = r; we = w; addr = {a1, a0}; wdata = {d1, d0};
    #1;
    g = (r == 2'b11) ? m_pref : r[1];
    chk("gnt", gnt, r == 0 ? 2'b00 : (g ? 2'b10 : 2'b01));
    for (int i = 0; i < 2; i++) begin
      if (r != 0 && int'(g) == i) begin
        checks++;
        if (wait_cnt[i] > MAX_BURST) begin
          errors++;
          $display("FAIL wait_bound: client %0d waited %0d cycles, limit %0d", i, wait_cnt[i], MAX_BURST);
        end
        wait_cnt[i] = 0;
      end else wait_cnt[i] = r[i] ? wait_cnt[i] + 1 : 0;
    end
    m_rv = 2'b00;
    if (r != 0) begin
      a = g ? a1 : a0;
      if (w[g]) begin
        m_mem[a] = g ? d1 : d0;
        m_known[a] = 1'b1;
      end else begin
        m_rv = g ? 2'b10 : 2'b01;
        m_rd = m_mem[a];
        m_rd_known = m_known[a];
      end
      m_run = (m_run > 0 && g == m_last) ? m_run + 1 : 1;
      m_last = g;
      m_pref = (m_run >= MAX_BURST) ? ~g : g;
    end else m_run = 0;
    if (r == 2'b11 && m_busy != 16'hFFFF) m_busy++;
  endtask

  initial begin
    tbl[0] = '{2'b01, 2'b01, 6'd5, 6'd0, 64'hDEAD_BEEF, 64'h0, 2'b01, 2'b00, 64'h0};
    tbl[1] = '{2'b01, 2'b00, 6'd5, 6'd0, 64'h0, 64'h0, 2'b01, 2'b00, 64'h0};
    tbl[2] = '{2'b10, 2'b10, 6'd0, 6'd7, 64'h0, 64'h2222, 2'b10, 2'b01, 64'hDEAD_BEEF};
    tbl[3] = '{2'b10, 2'b10, 6'd0, 6'd3, 64'h0, 64'h1111, 2'b10, 2'b00, 64'h0};
    tbl[4] = '{2'b10, 2'b00, 6'd0, 6'd7, 64'h0, 64'h0, 2'b10, 2'b00, 64'h0};
    tbl[5] = '{2'b01, 2'b01, 6'd9, 6'd0, 64'hA, 64'h0, 2'b01, 2'b10, 64'h2222};
    tbl[6] = '{2'b10, 2'b00, 6'd0, 6'd9, 64'h0, 64'h0, 2'b10, 2'b00, 64'h0};
    tbl[7] = '{2'b00, 2'b00, 6'd0, 6'd0, 64'h0, 64'h0, 2'b00, 2'b10, 64'hA};
    tbl[8] = '{2'b00, 2'b00, 6'd0, 6'd0, 64'h0, 64'h0, 2'b00, 2'b00, 64'h0};
    rst_n = 1'b0; req = 2'b11; we = 2'b00; addr = '0; wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_gnt", gnt, 2'b00);
    chk("reset_rvalid", rvalid, 2'b00);
    chk("reset_busy", busy_cnt, 16'h0);
    @(negedge clk);
    req = 2'b00;
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle(tbl[k].req, tbl[k].we, tbl[k].a0, tbl[k].a1, tbl[k].d0, tbl[k].d1);
      chk("tbl_gnt", gnt, tbl[k].gnt);
      chk("tbl_rvalid", rvalid, tbl[k].rv);
      if (tbl[k].rv != 0) chk("tbl_rdata", rdata, tbl[k].rd);
    end
    // Read granted, then reset lands on the edge that would have raised rvalid
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr = {6'd0, 6'd5};
    #1 chk("inflight_gnt", gnt, 2'b01);
    #2 rst_n = 1'b0;
    #1 chk("reset_gnt_low", gnt, 2'b00);
    @(posedge clk);
    #1;
    chk("inflight_rvalid", rvalid, 2'b00);
    chk("inflight_busy", busy_cnt, 16'h0);
    @(negedge clk);
    req = 2'b00;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(2'b11, 2'b00, 6'd5, 6'd7, 64'h0, 64'h0);
      chk("burst_gnt", gnt, ((k / MAX_BURST) % 2) ? 2'b10 : 2'b01);
    end
    cycle(2'b00, 2'b00, 6'd0, 6'd0, 64'h0, 64'h0);
    for (int i = 0; i < 64; i++)
      cycle(2'b01, 2'b01, 6'(i), 6'd0, {$urandom, $urandom}, 64'h0);
    for (int k = 0; k < 1500; k++)
      cycle(2'($urandom), 2'($urandom), 6'($urandom), 6'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom});
    cycle(2'b00, 2'b00, 6'd0, 6'd0, 64'h0, 64'h0);
    @(negedge clk);
    rst_n = 1'b0; req = 2'b11; we = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (65534) @(posedge clk);
    #1 chk("sat_fffe", busy_cnt, 16'hFFFE);
    @(posedge clk);
    #1 chk("sat_ffff", busy_cnt, 16'hFFFF);
    repeat (4464) @(posedge clk);
    #1 chk("sat_hold", busy_cnt, 16'hFFFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one ram_2port instance (1 write port, 1 read port) between two requesters (client 0: page-table walker, client 1: allocator/free-list logic) in the MMU.
- Performs round-robin arbitration with a bounded burst length, so exactly one access (read or write) is issued to the RAM per cycle.
- Returns read data one cycle after the grant, tagged to the owning client.
- Drives the RAM address ports so that the RAM's same-address write-to-read bypass never corrupts a read.

Parameters:
- ADDR_WIDTH, 6, RAM address width (depth = 1<<ADDR_WIDTH).
- DATA_WIDTH, 64, RAM word width.
- MAX_BURST, 4, maximum consecutive grants to one client while the other client is requesting (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  2  per-client request; bit i = client i.
- we  in  2  per-client op: 1 = write, 0 = read; sampled with req.
- addr  in  2*ADDR_WIDTH  client i address at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  2*DATA_WIDTH  client i write data at [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  2  one-hot-or-zero, combinational grant this cycle; request consumed when req[i]&gnt[i].
- rvalid  out  2  registered; bit i high for one cycle carrying client i's read data.
- rdata  out  DATA_WIDTH  read data, valid only when rvalid != 0.
- busy_cnt  out  16  registered count of cycles in which both clients requested (saturating).

Behaviour:
- Reset (rst_n=0 at edge): rvalid=0, busy_cnt=0, priority pointer=client 0, burst counter=0. gnt=0 while rst_n=0. RAM contents are not cleared.
- Arbitration (combinational from req, pointer, burst counter):
  - Only one requester: grant it.
  - Both requesting: grant the pointer client unless the burst counter == MAX_BURST-1 and that client was the last granted; in that case grant the other client.
  - Pointer update on a grant: pointer <= granted client while the burst is under the limit. When the burst hits the limit, or on any grant to the non-pointer client, pointer <= the other client.
  - Burst counter: increments on a repeat grant to the same client; resets to 0 on a switch of client or on any idle cycle (req=0).
- RAM drive on grant to client g:
  - Write: write_en=1, write_addr=addr[g], write_data=wdata[g], read_addr=~addr[g]. No rvalid.
  - Read: write_en=0, read_addr=addr[g], write_addr=~addr[g], write_data=0. This guarantees read_addr != write_addr, so the RAM bypass does not fire.
  - No grant: write_en=0, read_addr=0, write_addr=all ones.
- Read latency: grant at cycle N gives rvalid[g]=1 and rdata=mem[addr] at cycle N+1 (RAM register output).
  - rvalid is registered from (grant & ~we).
  - rdata is the RAM read_data passed through.
- Read after write, same address, back-to-back:
  - Write at N, read at N+1 → the read returns the new data at N+2.
  - Same-cycle write/read is impossible (single grant).
- Full throughput: one access per cycle. No backpressure on rvalid; clients must accept read data.
- Starvation bound: a requesting client waits at most MAX_BURST cycles.
- busy_cnt increments when req==2'b11, saturating at 16'hFFFF.
- Reset asserted with a read in flight: the rvalid for that read is suppressed (0 after reset).
- req deasserted without gnt: legal; nothing is recorded.

Decomposition:
- Shared package mmu_pkg:
  - Client index constants CLI_PTW=0, CLI_ALLOC=1.
  - NUM_CLIENTS=2.
  - Default widths ADDR_WIDTH, DATA_WIDTH.
- Sub-module: one instance of ram_2port (u_ram) with ADDR_WIDTH/DATA_WIDTH passed through.
- Arbitration and pointer logic stay in this module.

Test Plan:
- Reset then single client 0 writes addr 5 = 64'hDEAD_BEEF, next cycle reads addr 5 → gnt[0] both cycles, rvalid=2'b01 two cycles after the write with rdata=64'hDEAD_BEEF.
- Client 1 writes addr 3 = 64'h1111, then reads addr 7 (previously 64'h2222) → rdata=64'h2222; checks that the bypass is not triggered by stale write_data.
- Both clients reading continuously, MAX_BURST=4 → grant pattern 0,0,0,0,1,1,1,1,0...; no client waits more than 4 cycles; busy_cnt increments every cycle.
- Client 0 writes addr 9 = 64'hA at cycle N, client 1 reads addr 9 at N+1 → client 1 gets rvalid=2'b10, rdata=64'hA at N+2.
- Read granted at cycle N, rst_n=0 at N+1 → rvalid=0 at N+1, gnt=0 during reset; after release, the pointer favours client 0.
- Hold req=2'b11 for 70000 cycles → busy_cnt saturates at 16'hFFFF and does not wrap.
